// File: rtl/inc_loop_counter.sv
// Loop-index controller wrapped around an external incrementer.
// Count drives the incrementer operand and captures its result on each accepted step.
module inc_loop_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] init_i,
  input  logic [WIDTH-1:0] limit_i,
  input  logic             step_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] incA_o,
  input  logic [WIDTH-1:0] incD_i,
  output logic [WIDTH-1:0] count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           stateQ, stateD;
  logic [WIDTH-1:0] countQ, countD;
  logic [WIDTH-1:0] limQ, limD;
  logic             ovfQ, ovfD;

  logic atLimit;
  logic atMax;

  assign atLimit = (countQ == limQ);
  assign atMax   = (countQ == {WIDTH{1'b1}});

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateQ <= IDLE;
      countQ <= '0;
      limQ   <= '0;
      ovfQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      countQ <= countD;
      limQ   <= limD;
      ovfQ   <= ovfD;
    end
  end

  // RUN decisions are ordered: abort, then terminal value, then step (with wrap).
  always_comb begin
    stateD = stateQ;
    countD = countQ;
    limD   = limQ;
    ovfD   = ovfQ;
    unique case (stateQ)
      IDLE: begin
        if (start_i) begin
          countD = init_i;
          limD   = limit_i;
          ovfD   = 1'b0;
          stateD = RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          stateD = IDLE;
        end else if (atLimit) begin
          stateD = DONE;
        end else if (step_i) begin
          countD = incD_i;
          if (atMax) begin
            ovfD   = 1'b1;
            stateD = DONE;
          end
        end
      end
      DONE: begin
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  always_comb begin
    busy_o = (stateQ == RUN);
    done_o = (stateQ == DONE);
  end

  assign incA_o  = countQ;
  assign count_o = countQ;
  assign ovf_o   = ovfQ;

endmodule

// File: tb/tb_inc_loop_counter.sv
// Scoreboarded bench for inc_loop_counter at WIDTH=8 with an ideal incrementer.
// Expected per-cycle outputs come from an arithmetic loop model and are checked by a separate monitor.
module tb_inc_loop_counter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             step = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] init = '0;
  logic [WIDTH-1:0] limit = '0;
  logic [WIDTH-1:0] incA;
  logic [WIDTH-1:0] incD;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             ovf;

  typedef struct {
    int count;
    int busy;
    int done;
    int ovf;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: mode 0=idle, 1=looping, 2=finished-pulse
  int mMode = 0;
  int mCount = 0;
  int mLim = 0;
  int mOvf = 0;

  inc_loop_counter #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .init_i  (init),
    .limit_i (limit),
    .step_i  (step),
    .abort_i (abort),
    .incA_o  (incA),
    .incD_i  (incD),
    .count_o (count),
    .busy_o  (busy),
    .done_o  (done),
    .ovf_o   (ovf)
  );

  assign incD = incA + 8'd1;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  task automatic modelCycle(input int s, input int i, input int l, input int st, input int ab);
    if (mMode == 0) begin
      if (s != 0) begin
        mCount = i;
        mLim   = l;
        mOvf   = 0;
        mMode  = 1;
      end
    end else if (mMode == 1) begin
      if (ab != 0) begin
        mMode = 0;
      end else if (mCount == mLim) begin
        mMode = 2;
      end else if (st != 0) begin
        mCount = (mCount + 1) % 256;
        if (mCount == 0) begin
          mOvf  = 1;
          mMode = 2;
        end
      end
    end else begin
      mMode = 0;
    end
  endtask

  task automatic applyStimulus(input int s, input int i, input int l, input int st, input int ab);
    exp_t e;
    @(negedge clk);
    start = (s != 0);
    init  = WIDTH'(i);
    limit = WIDTH'(l);
    step  = (st != 0);
    abort = (ab != 0);
    modelCycle(s, i, l, st, ab);
    e.count = mCount;
    e.busy  = (mMode == 1) ? 1 : 0;
    e.done  = (mMode == 2) ? 1 : 0;
    e.ovf   = mOvf;
    expQ.push_back(e);
    @(posedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_count"}, int'(count), 0);
    checkOutput({tag, "_incA"}, int'(incA), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_done"}, int'(done), 0);
    checkOutput({tag, "_ovf"}, int'(ovf), 0);
  endtask

  // Reset lands between clock edges and is checked before any further edge.
  task automatic applyAsyncReset();
    @(negedge clk);
    start = 1'b0;
    step  = 1'b0;
    abort = 1'b0;
    #2 rst = 1'b1;
    #1 checkResetState("asyncRst");
    #1 rst = 1'b0;
    mMode  = 0;
    mCount = 0;
    mLim   = 0;
    mOvf   = 0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("count", int'(count), e.count);
      checkOutput("incA", int'(incA), e.count);
      checkOutput("busy", int'(busy), e.busy);
      checkOutput("done", int'(done), e.done);
      checkOutput("ovf", int'(ovf), e.ovf);
    end
  end

  initial begin
    #1 rst = 1'b1;
    #2 checkResetState("powerOn");
    @(negedge clk);
    rst = 1'b0;

    // Basic loop 3..6 with a Start attempt during the Done cycle
    applyStimulus(1, 3, 6, 1, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 40, 50, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Stalled steps 10..12
    applyStimulus(1, 10, 12, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0);

    // Wrap from 254 past all-ones, then a single-value loop clears Ovf
    applyStimulus(1, 254, 5, 1, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 0);

    // Abort beats Step; Start during RUN has no effect
    applyStimulus(1, 0, 100, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 77, 78, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Async reset mid-loop at Count=5, then a normal 7..8 loop
    applyStimulus(1, 0, 20, 0, 0);
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 1, 0);
    applyAsyncReset();
    applyStimulus(1, 7, 8, 1, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 1, 0);

    for (int k = 0; k < 600; k++) begin
      int s, i, l, st, ab;
      s  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      i  = int'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) l = int'($urandom_range(0, 255));
      else l = (i + int'($urandom_range(0, 5))) % 256;
      st = ($urandom_range(0, 3) != 0) ? 1 : 0;
      ab = ($urandom_range(0, 40) == 0) ? 1 : 0;
      applyStimulus(s, i, l, st, ab);
    end

    applyStimulus(0, 0, 0, 0, 0);
    #3;
    checkOutput("queueDrained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inc_loop_counter.md
Name: inc_loop_counter

Overview:
- Registered loop-index controller that sits around the combinational incrementer stage in the datapath.
- Drives the incrementer's operand from its count register and captures the incrementer's result back into that register on each step.
- Sequences a counted loop from Init to Limit with a Start/Busy/Done handshake, Abort, and wrap detection.
- Used by generated HLSM controllers to implement for-loop indices.

Parameters:
- WIDTH, 64, data width of count, bounds, and incrementer interface (must match the incrementer instance).

Ports:
- Clk    input   1      rising-edge clock
- Rst    input   1      asynchronous, active-high reset
- Start  input   1      request to begin a loop; sampled only in IDLE
- Init   input   WIDTH  start value, sampled on accepted Start
- Limit  input   WIDTH  terminal value, sampled on accepted Start into an internal register
- Step   input   1      advance the index by one this cycle (RUN only)
- Abort  input   1      terminate loop without Done (RUN only)
- IncA   output  WIDTH  operand to the incrementer; combinationally equal to Count
- IncD   input   WIDTH  result from the incrementer (IncA+1 mod 2^WIDTH)
- Count  output  WIDTH  current loop index (registered)
- Busy   output  1      high in RUN
- Done   output  1      one-cycle pulse on normal or overflow termination
- Ovf    output  1      sticky wrap flag; cleared on accepted Start

Behaviour:
- Reset (async, Rst=1): state=IDLE; Count=0, LimR=0, Busy=0, Done=0, Ovf=0. Reset takes effect immediately, including mid-loop.
- States and outputs:
  - IDLE: Busy=0, Done=0; Count holds. Start=1 -> Count<=Init, LimR<=Limit, Ovf<=0, next RUN.
  - RUN: Busy=1, Done=0.
  - DONE: Busy=0, Done=1 for exactly one cycle; next IDLE unconditionally.
- RUN priority, evaluated each cycle in this order:
  1. Abort=1 -> next IDLE; Count holds; no Done.
  2. Count==LimR -> next DONE; Count holds. Step is ignored, and the terminal value is observable for at least one RUN cycle.
  3. Step=1 and Count==all-ones -> Count<=IncD (0), Ovf<=1, next DONE.
  4. Step=1 -> Count<=IncD; stay RUN.
  5. Otherwise hold.
- Latency and timing:
  - Start-to-Busy latency is 1 cycle.
  - Each Step updates Count on the next edge.
  - Done is asserted 1 cycle after Count==LimR is first seen in RUN.
- Init==Limit: RUN for one cycle, then DONE. The loop visits exactly one value.
- Init>Limit (unsigned): counting wraps through all-ones. This terminates via Ovf with Count=0 and does not continue to Limit.
- Start is ignored outside IDLE, including in the DONE cycle. Step and Abort are ignored outside RUN.
- IncA follows Count combinationally. The block never computes +1 internally; it relies on IncD.
- Comparisons are unsigned and full-width.
- Count and Ovf hold after termination until the next accepted Start or reset.

Test Plan:
- Basic loop, WIDTH=8: Init=3, Limit=6, Start pulse, Step held high.
  - Count sequence 3,4,5,6; Busy high 4 cycles; Done pulses once at the cycle after Count=6 is first seen; Ovf=0; Count stays 6.
- Stalled steps: Init=10, Limit=12, Step toggled 1,0,0,1.
  - Count 10,11,11,11,12 follows Step exactly; Done only after 12; IncA always equals Count.
- Wrap, WIDTH=8: Init=254, Limit=5, Step high.
  - Count 254,255,0; Ovf=1; Done pulse; Count=0 remains.
  - A new Start with Init=1, Limit=1 clears Ovf and yields Done after one RUN cycle.
- Abort/priority: Init=0, Limit=100; after 3 steps assert Abort and Step together.
  - Count=3 held, IDLE next cycle, no Done. Start asserted during RUN earlier had no effect.
- Async reset mid-loop: Rst pulsed asynchronously (between clock edges) while Count=5 in RUN.
  - Count=0, Busy=0, Done=0, Ovf=0 immediately, without waiting for Clk.
  - After release, Start with Init=7, Limit=8 runs normally.
